// File: rtl/cpu_datapath.sv
// 8-bit accumulator datapath: PC, MAR, 16x8 RAM, IR, A, B, OUT and ALU around a
// single muxed internal bus. Every load samples the bus as it stood before the edge.
module cpu_datapath (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [14:0] ctrl,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [7:0]  prog_data,
    output logic [3:0]  opcode,
    output logic [7:0]  out_value,
    output logic        cf,
    output logic        zf,
    output logic [7:0]  bus_value,
    output logic        bus_conflict
);

    logic cp, ep, lp;
    logic ld_mar_addr, ld_mar_data;
    logic ram_oe, ram_we;
    logic ld_ir, ir_oe;
    logic ld_a, a_oe;
    logic alu_sub, alu_oe;
    logic ld_b, ld_out;

    // Active-low control bits are inverted here so the rest of the block reads positively.
    assign cp          = ctrl[14];
    assign ep          = ctrl[13];
    assign lp          = ctrl[12];
    assign ld_mar_addr = ~ctrl[11];
    assign ld_mar_data = ~ctrl[10];
    assign ram_oe      = ~ctrl[9];
    assign ram_we      = ~ctrl[8];
    assign ld_ir       = ~ctrl[7];
    assign ir_oe       = ~ctrl[6];
    assign ld_a        = ~ctrl[5];
    assign a_oe        = ctrl[4];
    assign alu_sub     = ctrl[3];
    assign alu_oe      = ctrl[2];
    assign ld_b        = ~ctrl[1];
    assign ld_out      = ~ctrl[0];

    logic [3:0] pc_reg;
    logic [3:0] mar_addr_reg;
    logic [7:0] mar_data_reg;
    logic [7:0] ir_reg;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] out_reg;
    logic       cf_reg;
    logic       zf_reg;
    logic [7:0] ram_reg [16];

    logic [7:0] ram_rdata;
    logic [8:0] alu_r;
    logic [7:0] alu_b;
    logic [2:0] n_src;
    logic [15:0] word_we;
    logic [7:0]  word_wdata;

    assign ram_rdata = ram_reg[mar_addr_reg];

    // Subtraction is A + ~B + 1, so r[8] is the "no borrow" flag.
    assign alu_b = alu_sub ? ~b_reg : b_reg;
    assign alu_r = {1'b0, a_reg} + {1'b0, alu_b} + {8'h00, alu_sub};

    always_comb begin
        bus_value = 8'h00;
        if (ram_oe)
            bus_value = ram_rdata;
        else if (ir_oe)
            bus_value = {4'h0, ir_reg[3:0]};
        else if (a_oe)
            bus_value = a_reg;
        else if (alu_oe)
            bus_value = alu_r[7:0];
        else if (ep)
            bus_value = {4'h0, pc_reg};
    end

    assign n_src = {2'b00, ram_oe} + {2'b00, ir_oe} + {2'b00, a_oe}
                 + {2'b00, alu_oe} + {2'b00, ep};
    assign bus_conflict = (n_src > 3'd1);

    // The program-load port owns the RAM write for its cycle; nLr is dropped then.
    assign word_wdata = prog_we ? prog_data : mar_data_reg;
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_word_we
            assign word_we[gi] = prog_we ? (prog_addr == 4'(gi))
                                         : (ram_we && (mar_addr_reg == 4'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++)
                ram_reg[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 16; i++)
                if (word_we[i])
                    ram_reg[i] <= word_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= 4'h0;
            mar_addr_reg <= 4'h0;
            mar_data_reg <= 8'h00;
            ir_reg       <= 8'h00;
            a_reg        <= 8'h00;
            b_reg        <= 8'h00;
            out_reg      <= 8'h00;
            cf_reg       <= 1'b0;
            zf_reg       <= 1'b0;
        end else begin
            if (lp)
                pc_reg <= bus_value[3:0];
            else if (cp)
                pc_reg <= pc_reg + 4'h1;
            if (ld_mar_addr)
                mar_addr_reg <= bus_value[3:0];
            if (ld_mar_data)
                mar_data_reg <= bus_value;
            if (ld_ir)
                ir_reg <= bus_value;
            if (ld_a)
                a_reg <= bus_value;
            if (ld_b)
                b_reg <= bus_value;
            if (ld_out)
                out_reg <= bus_value;
            if (alu_oe) begin
                cf_reg <= alu_r[8];
                zf_reg <= (alu_r[7:0] == 8'h00);
            end
        end
    end

    assign opcode    = ir_reg[7:4];
    assign out_value = out_reg;
    assign cf        = cf_reg;
    assign zf        = zf_reg;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: a vector table of control words with hand-computed
// bus/flag/output values, plus hand sequences for reset behaviour and a RAM sweep.
module tb_cpu_datapath;

    localparam logic [14:0] CP   = 15'h4000;
    localparam logic [14:0] EP   = 15'h2000;
    localparam logic [14:0] LP   = 15'h1000;
    localparam logic [14:0] NLMA = 15'h0800;
    localparam logic [14:0] NLMD = 15'h0400;
    localparam logic [14:0] NCE  = 15'h0200;
    localparam logic [14:0] NLR  = 15'h0100;
    localparam logic [14:0] NLI  = 15'h0080;
    localparam logic [14:0] NEI  = 15'h0040;
    localparam logic [14:0] NLA  = 15'h0020;
    localparam logic [14:0] EA   = 15'h0010;
    localparam logic [14:0] SUB  = 15'h0008;
    localparam logic [14:0] EU   = 15'h0004;
    localparam logic [14:0] NLB  = 15'h0002;
    localparam logic [14:0] NLO  = 15'h0001;
    localparam logic [14:0] IDLE = NLMA | NLMD | NCE | NLR | NLI | NEI | NLA | NLB | NLO;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] ctrl;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  opcode;
    logic [7:0]  out_value;
    logic        cf;
    logic        zf;
    logic [7:0]  bus_value;
    logic        bus_conflict;

    cpu_datapath dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl         (ctrl),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .opcode       (opcode),
        .out_value    (out_value),
        .cf           (cf),
        .zf           (zf),
        .bus_value    (bus_value),
        .bus_conflict (bus_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] ctrl;
        logic        pwe;
        logic [3:0]  paddr;
        logic [7:0]  pdata;
        logic [7:0]  bus;
        logic        conf;
        logic [3:0]  op;
        logic [7:0]  outv;
        logic        cf;
        logic        zf;
    } vec_t;

    vec_t vecs [80];
    int   nv = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // Expected post-edge register state attached to each vector as it is added.
    logic [3:0] e_op = 4'h0;
    logic [7:0] e_out = 8'h00;
    logic       e_cf = 1'b0;
    logic       e_zf = 1'b0;

    task automatic add(input logic [14:0] c, input logic pwe, input logic [3:0] pa,
                       input logic [7:0] pd, input logic [7:0] b, input logic cfl);
        vecs[nv].ctrl  = c;
        vecs[nv].pwe   = pwe;
        vecs[nv].paddr = pa;
        vecs[nv].pdata = pd;
        vecs[nv].bus   = b;
        vecs[nv].conf  = cfl;
        vecs[nv].op    = e_op;
        vecs[nv].outv  = e_out;
        vecs[nv].cf    = e_cf;
        vecs[nv].zf    = e_zf;
        nv++;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Program load
        add(IDLE, 1'b1, 4'h0, 8'h1E, 8'h00, 1'b0);
        add(IDLE, 1'b1, 4'h1, 8'hF0, 8'h00, 1'b0);
        add(IDLE, 1'b1, 4'h2, 8'h10, 8'h00, 1'b0);
        add(IDLE, 1'b1, 4'h3, 8'h05, 8'h00, 1'b0);
        add(IDLE, 1'b1, 4'h4, 8'h07, 8'h00, 1'b0);
        add(IDLE, 1'b1, 4'h5, 8'h55, 8'h00, 1'b0);
        add(IDLE & ~NLMA, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        e_op = 4'h1;
        add(IDLE & ~NCE & ~NLI, 1'b0, 4'h0, 8'h00, 8'h1E, 1'b0);
        // Addition F0 + 10
        add(IDLE | CP, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        add((IDLE | EP) & ~NLMA, 1'b0, 4'h0, 8'h00, 8'h01, 1'b0);
        add(IDLE & ~NCE & ~NLA, 1'b0, 4'h0, 8'h00, 8'hF0, 1'b0);
        add(IDLE | CP, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        add((IDLE | EP) & ~NLMA, 1'b0, 4'h0, 8'h00, 8'h02, 1'b0);
        add(IDLE & ~NCE & ~NLB, 1'b0, 4'h0, 8'h00, 8'h10, 1'b0);
        e_cf = 1'b1; e_zf = 1'b1;
        add((IDLE | EU) & ~NLA, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        add((IDLE | EA) & ~NLO, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        // Subtraction 05 - 07, then 05 - 05
        add(IDLE | CP, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        add((IDLE | EP) & ~NLMA, 1'b0, 4'h0, 8'h00, 8'h03, 1'b0);
        add(IDLE & ~NCE & ~NLA, 1'b0, 4'h0, 8'h00, 8'h05, 1'b0);
        add(IDLE | CP, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        add((IDLE | EP) & ~NLMA, 1'b0, 4'h0, 8'h00, 8'h04, 1'b0);
        add(IDLE & ~NCE & ~NLB, 1'b0, 4'h0, 8'h00, 8'h07, 1'b0);
        e_cf = 1'b0; e_zf = 1'b0;
        add(IDLE | EU | SUB, 1'b0, 4'h0, 8'h00, 8'hFE, 1'b0);
        add((IDLE | EA) & ~NLB, 1'b0, 4'h0, 8'h00, 8'h05, 1'b0);
        e_cf = 1'b1; e_zf = 1'b1;
        add(IDLE | EU | SUB, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        add((IDLE | EA) & ~NLA, 1'b0, 4'h0, 8'h00, 8'h05, 1'b0);
        // PC sweep from 4 through the F->0 wrap, bus shows pre-increment PC
        for (int k = 0; k < 16; k++)
            add(IDLE | CP | EP, 1'b0, 4'h0, 8'h00, 8'((4 + k) % 16), 1'b0);
        add((IDLE | CP | LP) & ~NCE, 1'b0, 4'h0, 8'h00, 8'h07, 1'b0);
        add(IDLE | EP, 1'b0, 4'h0, 8'h00, 8'h07, 1'b0);
        // Conflicts and RAM write ordering
        add((IDLE | EA) & ~NCE, 1'b0, 4'h0, 8'h00, 8'h07, 1'b1);
        add((IDLE | EA) & ~NLMD, 1'b0, 4'h0, 8'h00, 8'h05, 1'b0);
        add(IDLE & ~NLR, 1'b1, 4'h4, 8'hA5, 8'h00, 1'b0);
        add(IDLE & ~NCE & ~NLR, 1'b0, 4'h0, 8'h00, 8'hA5, 1'b0);
        e_out = 8'h05;
        add(IDLE & ~NCE & ~NLO, 1'b0, 4'h0, 8'h00, 8'h05, 1'b0);
        add(IDLE & ~NEI, 1'b0, 4'h0, 8'h00, 8'h0E, 1'b0);
        add((IDLE | EA) & ~NEI, 1'b0, 4'h0, 8'h00, 8'h0E, 1'b1);
        e_cf = 1'b0; e_zf = 1'b0;
        add(IDLE | EU | EP, 1'b0, 4'h0, 8'h00, 8'h0A, 1'b1);
        e_cf = 1'b1; e_zf = 1'b1;
        add(IDLE | EU | SUB, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        // A = OUT = 55 ahead of the reset test
        add(IDLE & ~NCE & ~NLMA, 1'b0, 4'h0, 8'h00, 8'h05, 1'b0);
        e_out = 8'h55;
        add(IDLE & ~NCE & ~NLA & ~NLO, 1'b0, 4'h0, 8'h00, 8'h55, 1'b0);

        // Power-on reset
        rst_n = 1'b0; ctrl = IDLE; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
        #3;
        chk("reset_opcode", {4'h0, opcode}, 8'h00);
        chk("reset_out", out_value, 8'h00);
        chk("reset_flags", {6'h00, cf, zf}, 8'h00);
        chk("reset_bus_idle", bus_value, 8'h00);
        ctrl = IDLE & ~NCE;
        #1;
        chk("reset_bus_ram0", bus_value, 8'h00);
        ctrl = IDLE;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            ctrl      = vecs[i].ctrl;
            prog_we   = vecs[i].pwe;
            prog_addr = vecs[i].paddr;
            prog_data = vecs[i].pdata;
            #2;
            chk($sformatf("v%0d_bus", i), bus_value, vecs[i].bus);
            chk($sformatf("v%0d_conflict", i), {7'h00, bus_conflict}, {7'h00, vecs[i].conf});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_opcode", i), {4'h0, opcode}, {4'h0, vecs[i].op});
            chk($sformatf("v%0d_out", i), out_value, vecs[i].outv);
            chk($sformatf("v%0d_flags", i), {6'h00, cf, zf}, {6'h00, vecs[i].cf, vecs[i].zf});
            $display("[TB] vec %0d ctrl=%04h bus=%02h conf=%0b op=%0h out=%02h cf=%0b zf=%0b",
                     i, vecs[i].ctrl, bus_value, bus_conflict, opcode, out_value, cf, zf);
        end

        // Asynchronous reset between edges with A=OUT=55 and flags set
        @(negedge clk);
        ctrl = IDLE; prog_we = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_out", out_value, 8'h00);
        chk("async_opcode", {4'h0, opcode}, 8'h00);
        chk("async_flags", {6'h00, cf, zf}, 8'h00);
        ctrl = IDLE | EA;
        #1;
        chk("async_a", bus_value, 8'h00);
        ctrl = IDLE & ~NCE;
        #1;
        chk("async_ram0", bus_value, 8'h00);
        $display("[TB] async reset out=%02h op=%0h cf=%0b zf=%0b", out_value, opcode, cf, zf);
        ctrl = IDLE;
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep every RAM word through MAR driven from the PC
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ctrl = (IDLE | EP | CP) & ~NLMA;
            @(negedge clk);
            ctrl = IDLE & ~NCE;
            #2;
            chk($sformatf("ram_clear_%0d", i), bus_value, 8'h00);
            $display("[TB] ram[%0d] after reset = %02h", i, bus_value);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: ctrl  input  15  control word from control_block; bit map is fixed as follows.
- [14] Cp: PC increment.
- [13] Ep: PC drives bus.
- [12] Lp: PC load.
- [11] nLma: MAR address load.
- [10] nLmd: MAR data load.
- [9] nCE: RAM drives bus.
- [8] nLr: RAM write.
- [7] nLi: IR load.
- [6] nEi: IR low nibble drives bus.
- [5] nLa: A load.
- [4] Ea: A drives bus.
- [3] sub: ALU subtracts.
- [2] Eu: ALU drives bus.
- [1] nLb: B load.
- [0] nLo: OUT load.
- Names starting with n are active-low; all others are active-high.
REQ-004 SHALL have port: opcode  output  4  IR[7:4], fed back to control_block.
REQ-005 SHALL have port: out_value  output  8  OUT register contents.
REQ-006 SHALL have ports: cf, zf  output  1 each  registered carry and zero flags.
REQ-007 SHALL have port: bus_value  output  8  current internal bus value, for debug.
REQ-008 SHALL have port: bus_conflict  output  1  high when more than one bus driver is enabled.
REQ-009 SHALL have ports: prog_we  input  1, prog_addr  input  4, prog_data  input  8  program-load write port.

Function
REQ-010 SHALL implement the bus as a combinational mux; no tri-states.
REQ-011 SHALL apply bus source priority RAM(nCE=0) > IR(nEi=0) > A(Ea) > ALU(Eu) > PC(Ep); with no source enabled, bus = 8'h00.
REQ-012 SHALL drive PC and IR onto the bus zero-extended: {4'h0, nibble}.
REQ-013 SHALL assert bus_conflict combinationally whenever two or more sources are enabled; priority still resolves the bus value.
REQ-014 SHALL have every load sample the pre-edge bus value, so a transfer takes 1 cycle and simultaneous loads all receive the same value.
REQ-015 SHALL provide a 4-bit PC with these edge rules:
- Lp=1: PC <= bus[3:0].
- else Cp=1: PC <= PC+1, wrapping 4'hF -> 4'h0.
- Lp=1 and Cp=1 together: load wins.
REQ-016 SHALL load MAR address from bus[3:0] when nLma=0 and the MAR data byte from bus[7:0] when nLmd=0; both may load in the same cycle.
REQ-017 SHALL provide RAM of 16x8 flops, read combinationally at the MAR address.
REQ-018 SHALL write RAM[MAR address] <= MAR data when nLr=0.
REQ-019 SHALL, when prog_we=1, write RAM[prog_addr] <= prog_data and suppress any nLr write in that cycle.
REQ-020 SHALL have a same-cycle RAM write and read return the old data; the new data is visible next cycle.
REQ-021 SHALL load IR from bus on nLi=0, A on nLa=0, B on nLb=0, OUT on nLo=0.
REQ-022 SHALL compute the ALU result as r[8:0] = A + (sub ? ~B : B) + sub, with result r[7:0].
REQ-023 SHALL latch flags only on edges where Eu=1: cf <= r[8], zf <= (r[7:0]==0); otherwise flags hold.
REQ-024 SHALL treat subtract cf=1 as "no borrow" (A >= B unsigned).
REQ-025 SHALL have a register loading from a bus it also drives (e.g. Ea with nLa=0) reload its own value; this is not a conflict.
REQ-026 SHALL keep ALU operands as current A and B; A loaded from the ALU result in cycle N is used as an operand from cycle N+1.

Reset
REQ-027 SHALL, while rst_n=0, clear immediately and asynchronously: PC, MAR address, MAR data, IR, A, B, OUT, cf, zf and all 16 RAM words.
REQ-028 SHALL therefore output opcode=0, out_value=0, cf=0, zf=0 during reset.
REQ-029 SHALL, after reset, present bus_value = RAM[0] if nCE=0, else 0.
REQ-030 SHALL have reset asserted mid-program clear state within the same cycle, with no partial write completing; the first edge after release acts on the ctrl present.

Verification
REQ-031 SHALL cover program load:
- prog_we writes 8'h1E to addr 0.
- MAR address <= 0, then nCE=0 with nLi=0.
- Required: opcode=4'h1 and bus_value=8'h1E in the read cycle.
REQ-032 SHALL cover addition:
- A=8'hF0, B=8'h10, Eu=1, sub=0, nLa=0.
- Required: A=8'h00, cf=1, zf=1.
- Then nLo=0 with Ea=1 gives out_value=8'h00.
REQ-033 SHALL cover subtraction:
- A=8'h05, B=8'h07, sub=1, Eu=1.
- Required: bus_value=8'hFE, cf=0, zf=0.
- Repeat with B=8'h05: bus_value=0, cf=1, zf=1.
REQ-034 SHALL cover the PC:
- 16 cycles with Cp=1: PC wraps 4'hF -> 4'h0.
- Cp=1, Lp=1, bus=8'h07: PC=7.
- Ep=1: bus_value=8'h07.
REQ-035 SHALL cover a bus conflict:
- nCE=0 and Ea=1 together.
- Required: bus_conflict=1 and bus_value = RAM data.
- nLr=0 with prog_we=1 to the same address: the prog_data value is stored.
REQ-036 SHALL cover async reset:
- Pull rst_n low between edges after A=8'h55 and out_value=8'h55.
- Required: A, out_value, cf, zf and all RAM read 0 before the next edge.
